// File: rtl/byte_pack128_if.sv
// Byte-stream in / 128-bit block out handshake bundle for byte_pack128.
// slave is the packer; master is the upstream source plus downstream sink.
interface byte_pack128_if;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] out_word;
    logic [4:0]   out_nbytes;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_byte, in_valid, in_last, out_ready,
        output in_ready, out_word, out_nbytes, out_valid
    );

    modport master (
        output in_byte, in_valid, in_last, out_ready,
        input  in_ready, out_word, out_nbytes, out_valid
    );
endinterface

// File: rtl/byte_pack128.sv
// Packs an 8-bit byte stream into 128-bit blocks, first byte in [127:120].
// A last flag closes a short block early; unwritten bytes are zero.
module byte_pack128 (
    input logic           clk,
    input logic           rst,
    byte_pack128_if.slave bus
);
    logic [127:0] acc_q, acc_d, acc_ins;
    logic [127:0] word_q, word_d;
    logic [4:0]   nbytes_q, nbytes_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         in_ready;
    logic         accept;
    logic         complete;

    // Only a pending word the sink is not taking this cycle blocks input.
    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign complete = accept && (cnt_q == 4'd15 || bus.in_last);

    always_comb begin
        acc_ins = acc_q;
        for (int i = 0; i < 16; i++) begin
            if (cnt_q == 4'(i)) begin
                acc_ins[127 - 8 * i -: 8] = bus.in_byte;
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        nbytes_d = nbytes_q;
        valid_d  = valid_q;
        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            if (complete) begin
                word_d   = acc_ins;
                nbytes_d = {1'b0, cnt_q} + 5'd1;
                valid_d  = 1'b1;
                cnt_d    = 4'd0;
                acc_d    = '0;
            end else begin
                acc_d = acc_ins;
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= 4'd0;
            word_q   <= '0;
            nbytes_q <= 5'd0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            nbytes_q <= nbytes_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_word   = word_q;
    assign bus.out_nbytes = nbytes_q;
    assign bus.out_valid  = valid_q;
endmodule

// File: tb/tb_byte_pack128.sv
// Directed and scoreboard checks for byte_pack128.
module tb_byte_pack128;
    logic clk = 1'b0;
    logic rst = 1'b1;
    byte_pack128_if bus ();

    byte_pack128 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        bus.in_last  = last;
        tick();
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    logic [127:0] exp_word;
    logic [127:0] held_word;
    logic [127:0] q_word[$];
    logic [4:0]   q_nb[$];
    logic [7:0]   rb;
    int           len, idx, blocks_sent, blocks_got, cyc;

    initial begin
        bus.in_byte   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_word", bus.out_word, '0);
        check("rst_nbytes", 128'(bus.out_nbytes), 128'd0);
        check("rst_valid", 128'(bus.out_valid), 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd1);

        // Full block 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            if (i == 14) check("full_valid_early", 128'(bus.out_valid), 128'd0);
        end
        check("full_valid", 128'(bus.out_valid), 128'd1);
        check("full_word", bus.out_word, 128'h000102030405060708090A0B0C0D0E0F);
        check("full_nbytes", 128'(bus.out_nbytes), 128'd16);
        idle();
        tick();
        check("full_valid_1cyc", 128'(bus.out_valid), 128'd0);

        // Short block with last
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("short_word", bus.out_word, {24'hAABBCC, 104'd0});
        check("short_nbytes", 128'(bus.out_nbytes), 128'd3);
        idle();
        tick();
        check("short_valid_clr", 128'(bus.out_valid), 128'd0);

        // Stall: word held, no input accepted
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h30 + 8'(i), 1'b0);
        held_word = 128'h303132333435363738393A3B3C3D3E3F;
        check("stall_word", bus.out_word, held_word);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        for (int i = 0; i < 10; i++) begin
            check("stall_in_ready", 128'(bus.in_ready), 128'd0);
            tick();
            check("stall_hold", bus.out_word, held_word);
        end
        check("stall_valid", 128'(bus.out_valid), 128'd1);
        bus.out_ready = 1'b1;
        #1;
        check("stall_ready_comb", 128'(bus.in_ready), 128'd1);
        tick();
        check("stall_xfer", 128'(bus.out_valid), 128'd0);
        send(8'h66, 1'b1);
        check("stall_next_word", bus.out_word, {16'h5566, 112'd0});
        check("stall_next_nb", 128'(bus.out_nbytes), 128'd2);
        idle();
        tick();

        // 32 back-to-back bytes
        for (int k = 1; k <= 32; k++) begin
            check("b2b_in_ready", 128'(bus.in_ready), 128'd1);
            send(8'h10 + 8'(k - 1), 1'b0);
            check("b2b_valid", 128'(bus.out_valid), 128'((k == 16) || (k == 32)));
            if (k == 16) check("b2b_word0", bus.out_word, 128'h101112131415161718191A1B1C1D1E1F);
            if (k == 32) check("b2b_word1", bus.out_word, 128'h202122232425262728292A2B2C2D2E2F);
        end
        idle();
        tick();

        // Async reset with a pending word, then mid-block
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst_word", bus.out_word, '0);
        check("arst_nbytes", 128'(bus.out_nbytes), 128'd0);
        check("arst_valid", 128'(bus.out_valid), 128'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(8'h77, 1'b0);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("arst2_valid", 128'(bus.out_valid), 128'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) send(8'hF0 + 8'(i), 1'b0);
        check("post_rst_word", bus.out_word, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
        check("post_rst_nb", 128'(bus.out_nbytes), 128'd16);
        idle();
        tick();

        // Random gaps and backpressure against a scoreboard
        blocks_sent = 0;
        blocks_got  = 0;
        idx         = 0;
        len         = $urandom_range(1, 16);
        exp_word    = '0;
        rb          = 8'($urandom);
        cyc         = 0;
        while ((blocks_got < 1000) && (cyc < 80000)) begin
            cyc++;
            bus.out_ready = 1'($urandom);
            if ((blocks_sent < 1000) && ($urandom_range(0, 1) == 1)) begin
                bus.in_valid = 1'b1;
                bus.in_byte  = rb;
                bus.in_last  = (idx == len - 1);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_byte  = 8'($urandom);
                bus.in_last  = 1'($urandom);
            end
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (q_word.size() == 0) begin
                    check("rnd_unexpected", 128'(bus.out_valid), 128'd0);
                end else begin
                    check("rnd_word", bus.out_word, q_word.pop_front());
                    check("rnd_nbytes", 128'(bus.out_nbytes), 128'(q_nb.pop_front()));
                end
                blocks_got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_word[127 - 8 * idx -: 8] = rb;
                idx++;
                rb = 8'($urandom);
                if (idx == len) begin
                    q_word.push_back(exp_word);
                    q_nb.push_back(5'(len));
                    blocks_sent++;
                    exp_word = '0;
                    idx      = 0;
                    len      = $urandom_range(1, 16);
                end
            end
            tick();
        end
        check("rnd_blocks", 128'(blocks_got), 128'd1000);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/byte_pack128.md
Name: byte_pack128

Overview:
Serial-to-parallel packer that collects an 8-bit byte stream into 128-bit blocks. It sits directly upstream of the 128-to-32 / 32-to-8 word splitters and feeds them a block only once the block is fully assembled. The first byte received lands in the most-significant byte position, so the splitters' w0 receives the first four bytes. A last-byte flag allows short blocks, which are zero-padded.

Parameters:
none (block width fixed at 128 bits / 16 bytes)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_byte  in  8  input byte
in_valid  in  1  in_byte valid
in_last  in  1  qualifies in_byte as final byte of current block (valid only with in_valid)
in_ready  out  1  packer can accept a byte this cycle
out_word  out  128  assembled block, first byte in [127:120]
out_nbytes  out  5  number of meaningful bytes in out_word, 1..16
out_valid  out  1  out_word/out_nbytes valid
out_ready  in  1  downstream accepts out_word this cycle

Behaviour:
- One clock domain. Reset is asynchronous and active-high; clock and reset ports are clk and rst.
- Reset values: out_word=0, out_nbytes=0, out_valid=0, internal byte count=0, accumulator=0.
- Reset mid-block discards all partial data. Reset while out_valid=1 drops the pending word.
- Input handshake: a byte is accepted when in_valid && in_ready on a rising edge.
- in_ready = !out_valid || out_ready. This is combinational from out_ready; no other term.
- While out_valid && !out_ready, no bytes are accepted, partial or otherwise. The accumulator and count hold.
- Placement: the k-th accepted byte of a block (k = 0..15) is written to accumulator bits [127-8k : 120-8k]. Unwritten positions remain 0.
- Count: 4-bit cnt, incremented per accepted byte. It never wraps on its own; completion resets it.
- Completion event: an accepted byte with cnt==15 or in_last=1. On the next edge:
  - out_word = accumulator including this byte, with remaining bytes 0;
  - out_nbytes = cnt+1;
  - out_valid = 1;
  - cnt = 0 and accumulator = 0.
- Latency: out_valid rises 1 cycle after the completing byte is accepted.
- Output handshake: the word transfers when out_valid && out_ready. out_valid then clears on that edge unless a completion event occurs in the same cycle, in which case the new block is loaded and out_valid stays 1.
- Result: back-to-back blocks flow with no bubbles when out_ready is held high.
- out_word and out_nbytes are stable while out_valid=1 and out_ready=0.
- in_last=1 with cnt==15 is a normal 16-byte block.
- in_last is ignored when in_valid=0.
- State view:
  - EMPTY: cnt=0, !out_valid
  - FILLING: cnt>0, !out_valid
  - HOLD: out_valid=1, with cnt 0..15 retained
  - FILLING+HOLD: legal, because collection continues while the downstream consumes each cycle.
- No error outputs. Bytes can never be lost or duplicated.

Test Plan:
- Reset, out_ready=1, send bytes 0x00..0x0F on 16 consecutive cycles -> 1 cycle after the 16th byte, out_valid=1 for exactly 1 cycle, out_word=0x000102030405060708090A0B0C0D0E0F, out_nbytes=16.
- Send 0xAA, 0xBB, then 0xCC with in_last=1 -> out_word=0xAABBCC followed by 26 hex zeros, out_nbytes=3. The next block starts at [127:120].
- Hold out_ready=0 after a completed block, keep in_valid=1 -> in_ready=0, out_word held constant for 10 cycles. Raise out_ready -> word transfers and in_ready=1 in the same cycle.
- Continuous 32 bytes 0x10..0x2F, out_ready=1 -> two words, 0x101112...1F then 0x202122...2F, out_valid high on cycles 17 and 33 with no bubble in acceptance.
- Send 5 bytes, assert rst asynchronously mid-cycle -> all outputs 0 immediately. After release, 16 bytes 0xF0..0xFF give out_word=0xF0F1...FF, out_nbytes=16 (no stale bytes).
- Random in_valid gaps (50%) with random out_ready -> scoreboard confirms byte order, zero padding and out_nbytes for 1000 blocks of random length 1..16.
